mips_cpu_ifetch: RTL and testbench
==================================

Name: mips_cpu_ifetch

Overview:
Instruction-fetch read master sitting between the PC unit and the instruction side of the Avalon-MM bus. It accepts a fetch address from the PC unit over a valid/ready handshake and issues one 32-bit bus read with byte-enable 4'b1111. It handles waitrequest and readdatavalid, then returns the instruction word to decode over a second valid/ready handshake. It also aborts cleanly on pipeline flush, traps misaligned addresses, and times out hung reads.

Parameters:
RESET_VECTOR, 32'hBFC00000, address driven on avm_address while idle and after reset
BYTE_SWAP, 1, 1 = reverse byte order of avm_readdata (little-endian bus to big-endian MIPS word); 0 = pass through
TIMEOUT_CYCLES, 255, maximum cycles from read issue to readdatavalid before bus_err; 8-bit counter width is fixed

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pc  in  32  fetch address from PC unit
pc_valid  in  1  pc holds a fetch request
pc_ready  out  1  request accepted this cycle
flush  in  1  discard any in-flight or held fetch (branch/jump redirect)
instr  out  32  fetched instruction word
instr_addr  out  32  address instr was fetched from
instr_valid  out  1  instr/instr_addr valid
instr_ready  in  1  decode consumes instr
addr_err  out  1  one-cycle pulse: accepted pc had pc[1:0]!=0
bus_err  out  1  one-cycle pulse: read timed out
avm_address  out  32  bus address
avm_read  out  1  bus read strobe
avm_byteenable  out  4  constant 4'b1111
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data valid

Behaviour:
- States: IDLE, REQ, WAIT, HOLD.
- Reset values:
  - state=IDLE; avm_read=0; avm_address=RESET_VECTOR.
  - instr=0; instr_addr=0; instr_valid=0.
  - addr_err=0; bus_err=0; discard=0; timeout counter=0.
- pc_ready:
  - 1 in IDLE when discard=0.
  - 1 in HOLD when instr_ready=1 (back-to-back accept).
  - 0 otherwise.
- Acceptance (pc_valid & pc_ready):
  - Latch pc into the address register.
  - If pc[1:0]!=0: pulse addr_err next cycle, issue no read, go to IDLE.
  - Else: go to REQ with avm_read=1 and avm_address=pc on the next cycle.
- REQ:
  - Hold avm_read and avm_address stable while avm_waitrequest=1.
  - On the cycle with avm_read=1 and avm_waitrequest=0: drop avm_read next cycle, go to WAIT, clear the counter.
  - If readdatavalid arrives in that same cycle, treat it as WAIT completion directly.
- WAIT:
  - Counter increments each cycle.
  - On avm_readdatavalid: instr=swap(readdata) per BYTE_SWAP; instr_addr=latched address; instr_valid=1; go to HOLD.
  - If counter reaches TIMEOUT_CYCLES first: pulse bus_err, go to IDLE, set discard=1. Any late readdatavalid is dropped and clears discard.
- HOLD:
  - instr, instr_addr and instr_valid hold until instr_ready=1.
  - On instr_ready: instr_valid falls next cycle unless a new pc is accepted in the same cycle; then go to IDLE or REQ.
- Latency: a zero-wait-state slave with readdatavalid one cycle after the read gives accept at cycle 0, avm_read at cycle 1, instr_valid at cycle 3. Throughput is one fetch per 3 cycles. Only one read is ever outstanding.
- flush (highest priority, any state):
  - instr_valid cleared next cycle.
  - In IDLE or HOLD: go to IDLE.
  - In REQ with waitrequest=1: deassert avm_read, go to IDLE. This abort is legal because the slave has not accepted the read.
  - In REQ with waitrequest=0 (read accepted that cycle), or in WAIT: set discard=1 and go to IDLE. The next readdatavalid is swallowed and clears discard.
  - pc_ready=0 while discard=1, so no new read issues until the stale response drains.
  - flush and pc_valid in the same cycle: flush wins; the request is not accepted.
- reset mid-read: everything returns to reset values. Any late readdatavalid is ignored because state is IDLE and discard=0.
- readdatavalid in IDLE/REQ/HOLD with discard=0: protocol violation, ignored.

Decomposition:
- Shared package mips_cpu_pkg:
  - fetch state enum (IDLE, REQ, WAIT, HOLD)
  - RESET_VECTOR constant
  - byte-swap function
- Natural sub-module: mips_cpu_ifetch_timeout, an 8-bit clear/enable counter with terminal-count output.

Test Plan:
1. Zero-wait slave, pc=32'hBFC00000, readdata=32'h0C000001, BYTE_SWAP=1 -> avm_read one cycle with address BFC00000; instr=32'h0100000C and instr_addr=BFC00000 at cycle 3.
2. waitrequest held high 4 cycles -> avm_read and avm_address stable for 5 cycles; exactly one read accepted; instr_valid once.
3. flush asserted in WAIT, slave returns data 2 cycles later -> instr_valid stays 0; pc_ready low until the stale readdatavalid; next pc=32'hBFC00010 fetched correctly.
4. pc=32'hBFC00002 -> addr_err one-cycle pulse; avm_read never asserted; state returns to IDLE.
5. Slave never asserts readdatavalid, TIMEOUT_CYCLES=8 -> bus_err pulses 8 cycles after read acceptance; a later readdatavalid is discarded.
6. instr_ready held low 5 cycles then high with pc_valid=1 -> instr stable during stall; new read issued the cycle after the handshake.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared fetch-path types, constants and helpers for the MIPS CPU.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] IFETCH_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [3:0]  AVM_BE_WORD         = 4'b1111;

  // Little-endian bus word to big-endian MIPS word.
  function automatic logic [31:0] byte_swap(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_ifetch_timeout.sv
// 8-bit clear/enable counter; tc flags the last permitted wait cycle.
module mips_cpu_ifetch_timeout #(
  parameter logic [7:0] TERMINAL = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = en && (count == TERMINAL - 8'd1);

endmodule

// File: rtl/mips_cpu_ifetch.sv
// Instruction-fetch Avalon-MM read master between the PC unit and decode,
// with flush abort, misaligned-PC trap and hung-read timeout.
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = IFETCH_RESET_VECTOR,
  parameter logic        BYTE_SWAP      = 1'b1,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  fetch_state_t state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_d;
  logic [31:0] iaddr_d;
  logic        discard_q, discard_d;
  logic        addr_err_d;
  logic        bus_err_d;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;
  logic [31:0] rd_word;

  assign rd_word = BYTE_SWAP ? byte_swap(avm_readdata)
                             : avm_readdata;

  assign avm_address    = addr_q;
  assign avm_read       = (state_q == REQ);
  assign avm_byteenable = AVM_BE_WORD;
  assign instr_valid    = (state_q == HOLD);

  assign cnt_clr = (state_q == REQ);
  assign cnt_en  = (state_q == WAIT);

  mips_cpu_ifetch_timeout #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= RESET_VECTOR;
      instr      <= '0;
      instr_addr <= '0;
      discard_q  <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr      <= instr_d;
      instr_addr <= iaddr_d;
      discard_q  <= discard_d;
      addr_err   <= addr_err_d;
      bus_err    <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr;
    iaddr_d    = instr_addr;
    discard_d  = discard_q;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    pc_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        pc_ready = ~discard_q & ~flush;
        // A stale response owed by the bus drains here.
        if (discard_q && avm_readdatavalid) begin
          discard_d = 1'b0;
        end
      end

      REQ: begin
        if (flush) begin
          state_d   = IDLE;
          discard_d = ~avm_waitrequest
                    & ~avm_readdatavalid;
        end else if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            state_d = HOLD;
            instr_d = rd_word;
            iaddr_d = addr_q;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (flush) begin
          state_d   = IDLE;
          discard_d = ~avm_readdatavalid;
        end else if (avm_readdatavalid) begin
          state_d = HOLD;
          instr_d = rd_word;
          iaddr_d = addr_q;
        end else if (cnt_tc) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          discard_d = 1'b1;
        end
      end

      HOLD: begin
        pc_ready = instr_ready & ~flush;
        if (flush || instr_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (pc_valid && pc_ready) begin
      addr_d = pc;
      if (pc[1:0] != 2'b00) begin
        addr_err_d = 1'b1;
        state_d    = IDLE;
      end else begin
        state_d = REQ;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Randomized and directed bench for mips_cpu_ifetch against a
// behavioural fetch model and a simple Avalon slave.
module tb_mips_cpu_ifetch;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam int          T  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        addr_err;
  logic        bus_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_cpu_ifetch #(
    .RESET_VECTOR   (RV),
    .BYTE_SWAP      (1'b1),
    .TIMEOUT_CYCLES (8'(T))
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .pc_ready          (pc_ready),
    .flush             (flush),
    .instr             (instr),
    .instr_addr        (instr_addr),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .addr_err          (addr_err),
    .bus_err           (bus_err),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] x);
    return ((x & 32'hFF) << 24) | (((x >> 8) & 32'hFF) << 16)
         | (((x >> 16) & 32'hFF) << 8) | ((x >> 24) & 32'hFF);
  endfunction

  // Slave knobs and pending response
  int          wr_pct  = 0;
  int          wr_hold = 0;
  int          dly_lo  = 1;
  int          dly_hi  = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data;

  // Reference model: what the fetch unit is doing right now
  logic        m_rd, m_aw, m_hold, m_stale, m_ae, m_be;
  int          m_age;
  logic [31:0] m_fa, m_word, m_ia;

  task automatic model_reset();
    m_rd = 0; m_aw = 0; m_hold = 0; m_stale = 0;
    m_ae = 0; m_be = 0; m_age = 0;
    m_fa = RV; m_word = 0; m_ia = 0;
  endtask

  function automatic logic model_ready();
    logic idle;
    idle = !m_rd && !m_aw && !m_hold;
    return !flush && ((idle && !m_stale) || (m_hold && instr_ready));
  endfunction

  task automatic slave_drive();
    int d;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (avm_read && wr_hold > 0) begin
      avm_waitrequest = 1'b1;
      wr_hold--;
    end else begin
      avm_waitrequest = ($urandom_range(99) < wr_pct);
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_data;
      end
    end
    if (avm_read && !avm_waitrequest) begin
      d = $urandom_range(dly_hi, dly_lo);
      rsp_data = (avm_address == RV) ? 32'h0C00_0001 : $urandom;
      if (d == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_data;
      end else begin
        rsp_cnt = d;
      end
    end
  endtask

  task automatic model_advance(input logic er);
    logic        n_rd, n_aw, n_hold, n_stale, n_ae, n_be;
    int          n_age;
    logic [31:0] n_fa, n_word, n_ia;
    n_rd = m_rd; n_aw = m_aw; n_hold = m_hold; n_stale = m_stale;
    n_age = m_age; n_fa = m_fa; n_word = m_word; n_ia = m_ia;
    n_ae = 0; n_be = 0;
    if (reset) begin
      n_rd = 0; n_aw = 0; n_hold = 0; n_stale = 0; n_age = 0;
      n_fa = RV; n_word = 0; n_ia = 0;
    end else begin
      if (m_stale && avm_readdatavalid) n_stale = 0;
      if (flush) begin
        if (m_rd) begin
          n_rd = 0;
          n_stale = !avm_waitrequest && !avm_readdatavalid;
        end
        if (m_aw) begin
          n_aw = 0;
          n_stale = !avm_readdatavalid;
        end
        n_hold = 0;
      end else begin
        if (m_rd && !avm_waitrequest) begin
          n_rd = 0;
          if (avm_readdatavalid) begin
            n_hold = 1; n_word = sw(avm_readdata); n_ia = m_fa;
          end else begin
            n_aw = 1; n_age = 0;
          end
        end else if (m_aw) begin
          if (avm_readdatavalid) begin
            n_aw = 0; n_hold = 1;
            n_word = sw(avm_readdata); n_ia = m_fa;
          end else if (m_age == T - 1) begin
            n_aw = 0; n_be = 1; n_stale = 1;
          end else begin
            n_age = m_age + 1;
          end
        end
        if (m_hold && instr_ready) n_hold = 0;
        if (pc_valid && er) begin
          n_fa = pc;
          if (pc % 4 != 0) n_ae = 1;
          else n_rd = 1;
        end
      end
    end
    m_rd = n_rd; m_aw = n_aw; m_hold = n_hold; m_stale = n_stale;
    m_ae = n_ae; m_be = n_be; m_age = n_age;
    m_fa = n_fa; m_word = n_word; m_ia = n_ia;
  endtask

  // One clock cycle: drive at negedge, compare, advance model.
  task automatic step(input logic pv, input logic [31:0] p,
                      input logic fl, input logic ir,
                      input logic rs);
    logic er;
    reset = rs; pc_valid = pv; pc = p; flush = fl; instr_ready = ir;
    slave_drive();
    #1;
    er = model_ready();
    check("pc_ready", pc_ready, er);
    check("avm_read", avm_read, m_rd);
    if (m_rd) check("avm_address", avm_address, m_fa);
    check("instr_valid", instr_valid, m_hold);
    if (m_hold) begin
      check("instr", instr, m_word);
      check("instr_addr", instr_addr, m_ia);
    end
    check("addr_err", addr_err, m_ae);
    check("bus_err", bus_err, m_be);
    check("byteenable", avm_byteenable, 4'hF);
    model_advance(er);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic pv,
                     input logic [31:0] p, input logic fl,
                     input logic ir, output int vcnt,
                     output int rcnt, output int ecnt);
    vcnt = 0; rcnt = 0; ecnt = 0;
    for (int i = 0; i < n; i++) begin
      if (instr_valid) vcnt++;
      if (avm_read) rcnt++;
      if (addr_err || bus_err) ecnt++;
      step(pv, p, fl, ir, 1'b0);
    end
  endtask

  initial begin
    int v, r, e, be_at, be_cnt;
    logic [31:0] p;
    reset = 1; pc = 0; pc_valid = 0; flush = 0; instr_ready = 0;
    avm_waitrequest = 0; avm_readdata = 0; avm_readdatavalid = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_read", avm_read, 0);
    check("rst_address", avm_address, RV);
    check("rst_instr", instr, 0);
    check("rst_instr_addr", instr_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_pc_ready", pc_ready, 1);

    // Zero-wait fetch latency
    step(1, RV, 0, 1, 0);
    check("t1_read", avm_read, 1);
    check("t1_addr", avm_address, RV);
    step(0, 0, 0, 1, 0);
    check("t1_read_drop", avm_read, 0);
    step(0, 0, 0, 1, 0);
    check("t1_valid", instr_valid, 1);
    check("t1_instr", instr, 32'h0100_000C);
    check("t1_iaddr", instr_addr, RV);
    step(0, 0, 0, 1, 0);

    // Waitrequest stall
    wr_hold = 4;
    step(1, RV + 32'h40, 0, 1, 0);
    run(10, 0, 0, 0, 1, v, r, e);
    check("t2_read_cycles", r, 5);
    check("t2_valid_cycles", v, 1);

    // Flush in WAIT, stale response drains
    dly_lo = 3; dly_hi = 3;
    step(1, RV + 32'h80, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    run(2, 1, RV + 32'h10, 0, 1, v, r, e);
    check("t3_no_valid", v, 0);
    check("t3_no_read", r, 0);
    dly_lo = 1; dly_hi = 1;
    step(1, RV + 32'h10, 0, 1, 0);
    check("t3_read", avm_read, 1);
    run(4, 0, 0, 0, 1, v, r, e);
    check("t3_valid", v, 1);

    // Misaligned PC
    step(1, RV + 32'h2, 0, 1, 0);
    check("t4_addr_err", addr_err, 1);
    check("t4_no_read", avm_read, 0);
    run(4, 0, 0, 0, 1, v, r, e);
    check("t4_read_cycles", r, 0);
    check("t4_pulse_len", e, 1);

    // Timeout, late response discarded
    dly_lo = 20; dly_hi = 20;
    step(1, RV + 32'h20, 0, 1, 0);
    be_at = -1; be_cnt = 0; v = 0;
    for (int i = 1; i <= 22; i++) begin
      if (bus_err) begin be_at = i; be_cnt++; end
      if (instr_valid) v++;
      if (i == 15) begin dly_lo = 1; dly_hi = 1; end
      step(i >= 15, RV + 32'h30, 0, 1, 0);
    end
    check("t5_bus_err_cycle", be_at, 10);
    check("t5_bus_err_count", be_cnt, 1);
    check("t5_late_dropped", v, 0);
    run(4, 0, 0, 0, 1, v, r, e);
    check("t5_refetch", v, 1);

    // Decode stall then back-to-back accept
    step(1, RV + 32'h100, 0, 0, 0);
    run(2, 0, 0, 0, 0, v, r, e);
    run(5, 0, 0, 0, 0, v, r, e);
    check("t6_stall_valid", v, 5);
    step(1, RV + 32'h104, 0, 1, 0);
    check("t6_read", avm_read, 1);
    check("t6_addr", avm_address, RV + 32'h104);
    check("t6_valid_drop", instr_valid, 0);
    run(4, 0, 0, 0, 1, v, r, e);

    // Randomized traffic
    wr_pct = 30; dly_lo = 0; dly_hi = 11;
    for (int i = 0; i < 3000; i++) begin
      p = RV + {22'd0, 8'($urandom_range(255)), 2'b00};
      if ($urandom_range(99) < 8) p[1:0] = 2'($urandom_range(3, 1));
      step($urandom_range(99) < 70, p,
           $urandom_range(99) < 6,
           $urandom_range(99) < 65,
           $urandom_range(999) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
